// File: rtl/param_reg_file_pkg.sv
// Shared definitions for the parametrised register file: per-register operation
// codes, copy-engine state encoding and copy-direction constants.
package param_reg_file_pkg;

    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;
    localparam logic [2:0] FS_CLR  = 3'b011;
    localparam logic [2:0] FS_SHL  = 3'b100;
    localparam logic [2:0] FS_SHR  = 3'b101;
    localparam logic [2:0] FS_ROL  = 3'b110;
    localparam logic [2:0] FS_ROR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } copy_state_t;

    localparam logic DIR_SAVE    = 1'b0;
    localparam logic DIR_RESTORE = 1'b1;

endpackage

// File: rtl/param_register.sv
// One WIDTH-bit register with the shared FunSel operation set and an
// active-low enable; a copy-load override wins over any FunSel operation.
module param_register #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [2:0]       FunSel,
    input  logic             EnableN,
    input  logic [WIDTH-1:0] I,
    input  logic             CopyLoad,
    input  logic [WIDTH-1:0] CopyVal,
    output logic [WIDTH-1:0] Q
);
    import param_reg_file_pkg::*;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= '0;
        end else if (CopyLoad) begin
            Q <= CopyVal;
        end else if (!EnableN) begin
            case (FunSel)
                FS_DEC:  Q <= Q - 1'b1;
                FS_INC:  Q <= Q + 1'b1;
                FS_LOAD: Q <= I;
                FS_CLR:  Q <= '0;
                FS_SHL:  Q <= {Q[WIDTH-2:0], 1'b0};
                FS_SHR:  Q <= {1'b0, Q[WIDTH-1:1]};
                FS_ROL:  Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
                FS_ROR:  Q <= {Q[0], Q[WIDTH-1:1]};
                default: Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/param_reg_file.sv
// General (R) and scratch (S) register banks with two combinational read ports
// and a bank-copy engine for context save (S<-R) / restore (R<-S).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | banks follow FunSel/RegSel/ScrSel; CopyStart is accepted
//   ST_COPY | one register pair copied per edge; bank writes are frozen
module param_reg_file #(
    parameter int   WIDTH = 16,
    parameter int   NUM_R = 4,
    parameter int   NUM_S = 4,
    localparam int  SEL_W = $clog2(NUM_R + NUM_S)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [NUM_R-1:0] RegSel,
    input  logic [NUM_S-1:0] ScrSel,
    input  logic [SEL_W-1:0] OutASel,
    input  logic [SEL_W-1:0] OutBSel,
    input  logic             CopyStart,
    input  logic             CopyDir,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB
);
    import param_reg_file_pkg::*;

    localparam int IDX_W = (NUM_R > 1) ? $clog2(NUM_R) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_R - 1);

    if (NUM_R < 1 || NUM_S < NUM_R) begin : g_bad_cfg
        $error("param_reg_file: requires NUM_R >= 1 and NUM_S >= NUM_R");
    end

    copy_state_t      state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             dir, dir_nxt;
    logic             done_nxt;

    logic [WIDTH-1:0] r_q [NUM_R];
    logic [WIDTH-1:0] s_q [NUM_S];
    logic [WIDTH-1:0] s_copy_val [NUM_S];
    logic [NUM_R-1:0] r_copy;
    logic [NUM_S-1:0] s_copy;

    assign Busy = (state == ST_COPY);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            dir   <= DIR_SAVE;
            Done  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            dir   <= dir_nxt;
            Done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        dir_nxt   = dir;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (CopyStart) begin
                    dir_nxt   = CopyDir;
                    idx_nxt   = '0;
                    state_nxt = ST_COPY;
                end
            end
            ST_COPY: begin
                if (idx == LAST_IDX) begin
                    idx_nxt   = '0;
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Enables are forced inactive while copying so the whole bank is frozen,
    // not just the pair currently being copied.
    for (genvar i = 0; i < NUM_R; i++) begin : g_r
        assign r_copy[i] = Busy && (dir == DIR_RESTORE) && (idx == IDX_W'(i));
        param_register #(.WIDTH(WIDTH)) u_reg (
            .Clock    (Clock),
            .Reset    (Reset),
            .FunSel   (FunSel),
            .EnableN  (RegSel[NUM_R-1-i] | Busy),
            .I        (I),
            .CopyLoad (r_copy[i]),
            .CopyVal  (s_q[i]),
            .Q        (r_q[i])
        );
    end

    for (genvar i = 0; i < NUM_S; i++) begin : g_s
        if (i < NUM_R) begin : g_paired
            assign s_copy[i]     = Busy && (dir == DIR_SAVE) && (idx == IDX_W'(i));
            assign s_copy_val[i] = r_q[i];
        end else begin : g_spare
            assign s_copy[i]     = 1'b0;
            assign s_copy_val[i] = '0;
        end
        param_register #(.WIDTH(WIDTH)) u_reg (
            .Clock    (Clock),
            .Reset    (Reset),
            .FunSel   (FunSel),
            .EnableN  (ScrSel[NUM_S-1-i] | Busy),
            .I        (I),
            .CopyLoad (s_copy[i]),
            .CopyVal  (s_copy_val[i]),
            .Q        (s_q[i])
        );
    end

    // Indices past the last scratch register fall through to zero.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < NUM_R; k++) begin
            if (OutASel == SEL_W'(k)) OutA = r_q[k];
            if (OutBSel == SEL_W'(k)) OutB = r_q[k];
        end
        for (int k = 0; k < NUM_S; k++) begin
            if (OutASel == SEL_W'(NUM_R + k)) OutA = s_q[k];
            if (OutBSel == SEL_W'(NUM_R + k)) OutB = s_q[k];
        end
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file (16-bit, 4+4): register operations, bank copy
// timing, copy write-blocking, reset abort and back-to-back copies.
module tb_param_reg_file;
    import param_reg_file_pkg::*;

    localparam int WIDTH = 16;
    localparam int NUM_R = 4;
    localparam int NUM_S = 4;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [WIDTH-1:0]  I;
    logic [2:0]        FunSel;
    logic [NUM_R-1:0]  RegSel;
    logic [NUM_S-1:0]  ScrSel;
    logic [2:0]        OutASel, OutBSel;
    logic              CopyStart, CopyDir;
    logic              Busy, Done;
    logic [WIDTH-1:0]  OutA, OutB;

    always #10 Clock = ~Clock;

    param_reg_file #(.WIDTH(WIDTH), .NUM_R(NUM_R), .NUM_S(NUM_S)) dut (
        .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel),
        .RegSel(RegSel), .ScrSel(ScrSel), .OutASel(OutASel), .OutBSel(OutBSel),
        .CopyStart(CopyStart), .CopyDir(CopyDir), .Busy(Busy), .Done(Done),
        .OutA(OutA), .OutB(OutB)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] m [8];           // model: 0..3 = R0..R3, 4..7 = S0..S3
    logic [15:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs;
        RegSel    = '1;
        ScrSel    = '1;
        FunSel    = FS_LOAD;
        CopyStart = 1'b0;
    endtask

    function automatic logic [15:0] model_op(input logic [2:0] fs, input logic [15:0] v, input logic [15:0] din);
        case (fs)
            3'b000:  return v - 16'd1;
            3'b001:  return v + 16'd1;
            3'b010:  return din;
            3'b011:  return 16'h0000;
            3'b100:  return v << 1;
            3'b101:  return v >> 1;
            3'b110:  return {v[14:0], v[15]};
            default: return {v[0], v[15:1]};
        endcase
    endfunction

    task automatic op(input logic [2:0] fs, input logic [15:0] din,
                      input logic [3:0] rs, input logic [3:0] ss);
        FunSel = fs; I = din; RegSel = rs; ScrSel = ss;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (!rs[3-i]) m[i]   = model_op(fs, m[i], din);
            if (!ss[3-i]) m[4+i] = model_op(fs, m[4+i], din);
        end
        idle_inputs();
    endtask

    // Expected values go into the scoreboard as the selects are driven and
    // come out once the read ports have settled.
    task automatic rd(input int sel, input string tag, input logic [15:0] expv);
        int bsel;
        bsel = (sel + 1) % 8;
        OutASel = sel[2:0];
        OutBSel = bsel[2:0];
        sb.push_back(expv);
        sb.push_back(m[bsel]);
        #1;
        check({tag, "_a"}, OutA, sb.pop_front());
        check({tag, "_b"}, OutB, sb.pop_front());
    endtask

    task automatic rd_all(input string tag);
        for (int k = 0; k < 8; k++) rd(k, $sformatf("%s_%0d", tag, k), m[k]);
    endtask

    task automatic copy_run(input string tag, input logic dir, input bit junk);
        CopyStart = 1'b1;
        CopyDir   = dir;
        tick();
        CopyStart = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("%s_busy%0d", tag, c), Busy, 1);
            check($sformatf("%s_nodone%0d", tag, c), Done, 0);
            if (junk) begin
                RegSel = '0; ScrSel = '0; FunSel = FS_CLR; CopyStart = 1'b1;
            end
            tick();
        end
        idle_inputs();
        check({tag, "_idle"}, Busy, 0);
        check({tag, "_done"}, Done, 1);
        tick();
        check({tag, "_done_once"}, Done, 0);
        check({tag, "_still_idle"}, Busy, 0);
        for (int i = 0; i < 4; i++) begin
            if (dir == DIR_SAVE) m[4+i] = m[i];
            else                 m[i]   = m[4+i];
        end
    endtask

    logic b_exp [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
    logic d_exp [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

    initial begin
        Reset = 1'b1; I = '0; CopyDir = 1'b0; OutASel = '0; OutBSel = '0;
        idle_inputs();
        tick();
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) m[k] = 16'h0000;
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        rd_all("reset");

        // load and read-back latency
        op(FS_LOAD, 16'h1234, 4'b0111, 4'b1111);
        rd(0, "load_r0", 16'h1234);
        rd(1, "load_r1", 16'h0000);

        // wrap-around arithmetic and shifts
        op(FS_LOAD, 16'hFFFF, 4'b1011, 4'b1111);
        op(FS_INC,  16'h0000, 4'b1011, 4'b1111);
        rd(1, "inc_wrap", 16'h0000);
        op(FS_DEC,  16'h0000, 4'b1011, 4'b1111);
        rd(1, "dec_wrap", 16'hFFFF);
        op(FS_LOAD, 16'h8001, 4'b1101, 4'b1111);
        op(FS_SHL,  16'h0000, 4'b1101, 4'b1111);
        rd(2, "shl", 16'h0002);
        op(FS_LOAD, 16'h8001, 4'b1101, 4'b1111);
        op(FS_ROL,  16'h0000, 4'b1101, 4'b1111);
        rd(2, "rol", 16'h0003);
        op(FS_LOAD, 16'h8001, 4'b1101, 4'b1111);
        op(FS_ROR,  16'h0000, 4'b1101, 4'b1111);
        rd(2, "ror", 16'hC000);
        op(FS_LOAD, 16'h8001, 4'b1101, 4'b1111);
        op(FS_SHR,  16'h0000, 4'b1101, 4'b1111);
        rd(2, "shr", 16'h4000);
        op(FS_LOAD, 16'h00F0, 4'b1111, 4'b0110);
        op(FS_CLR,  16'h0000, 4'b1111, 4'b1110);
        rd_all("multi");

        // save R -> S
        op(FS_LOAD, 16'h1111, 4'b0111, 4'b1111);
        op(FS_LOAD, 16'h2222, 4'b1011, 4'b1111);
        op(FS_LOAD, 16'h3333, 4'b1101, 4'b1111);
        op(FS_LOAD, 16'h4444, 4'b1110, 4'b1111);
        op(FS_LOAD, 16'h0BAD, 4'b1111, 4'b0000);
        copy_run("save", DIR_SAVE, 1'b0);
        rd(4, "save_s0", 16'h1111);
        rd(7, "save_s3", 16'h4444);
        rd_all("save");

        // writes and a second CopyStart while busy are ignored
        op(FS_LOAD, 16'h5A5A, 4'b0000, 4'b1111);
        op(FS_INC,  16'h0000, 4'b1010, 4'b1111);
        copy_run("blk", DIR_SAVE, 1'b1);
        rd_all("blk");

        // reset in the second busy cycle of a restore aborts it
        op(FS_LOAD, 16'hAAAA, 4'b1111, 4'b0000);
        op(FS_LOAD, 16'h7777, 4'b0000, 4'b1111);
        CopyStart = 1'b1; CopyDir = DIR_RESTORE;
        tick();
        CopyStart = 1'b0;
        check("abort_busy1", Busy, 1);
        tick();
        check("abort_busy2", Busy, 1);
        rd(0, "abort_partial_r0", 16'hAAAA);
        rd(1, "abort_partial_r1", 16'h7777);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) m[k] = 16'h0000;
        check("abort_busy_clr", Busy, 0);
        check("abort_done_clr", Done, 0);
        rd_all("abort");
        for (int c = 0; c < 5; c++) begin
            check($sformatf("abort_nodone%0d", c), Done | Busy, 0);
            tick();
        end

        // CopyStart held across Done starts the next copy immediately
        op(FS_LOAD, 16'hC3C3, 4'b0000, 4'b1111);
        op(FS_DEC,  16'h0000, 4'b0101, 4'b1111);
        CopyStart = 1'b1; CopyDir = DIR_SAVE;
        tick();
        for (int c = 0; c < 11; c++) begin
            check($sformatf("b2b_busy%0d", c), Busy, b_exp[c]);
            check($sformatf("b2b_done%0d", c), Done, d_exp[c]);
            if (c == 5) CopyStart = 1'b0;
            tick();
        end
        for (int i = 0; i < 4; i++) m[4+i] = m[i];
        rd_all("b2b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_reg_file.md
Name: param_reg_file

Overview:
- Parametrised successor to the 4+4 x 16-bit register file.
- Provides configurable width and configurable general (R) and scratch (S) bank depths.
- Keeps the shared 3-bit FunSel per-register operation set and two combinational read ports.
- Adds a multi-cycle bank-copy engine (save R→S / restore S→R) with a Busy/Done handshake, used by the control unit for context save/restore around subroutine and interrupt entry.

Parameters:
WIDTH, 16, data width of every register and of I/OutA/OutB
NUM_R, 4, number of general registers R0..R(NUM_R-1); must be ≥1
NUM_S, 4, number of scratch registers S0..S(NUM_S-1); must be ≥NUM_R (elaboration-time error otherwise)
SEL_W, $clog2(NUM_R+NUM_S), read-select width (derived, not overridden)

Ports:
Clock  input  1  single clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
I  input  WIDTH  load data
FunSel  input  3  operation applied to every enabled register
RegSel  input  NUM_R  active-low enables; bit NUM_R-1-i enables Ri (MSB = R0)
ScrSel  input  NUM_S  active-low enables; bit NUM_S-1-i enables Si (MSB = S0)
OutASel  input  SEL_W  read index A: 0..NUM_R-1 → Ri, NUM_R..NUM_R+NUM_S-1 → S(idx-NUM_R)
OutBSel  input  SEL_W  read index B, same map
CopyStart  input  1  request bank copy, sampled only when idle
CopyDir  input  1  0 = save (Si←Ri), 1 = restore (Ri←Si), sampled with CopyStart
Busy  output  1  copy in progress
Done  output  1  one-cycle pulse after the last copy write
OutA  output  WIDTH  combinational read A
OutB  output  WIDTH  combinational read B

Behaviour:
- Clock and reset: one clock (Clock); Reset is synchronous and active-high. Reset forces all registers to 0, Busy=0, Done=0, FSM to IDLE, copy index to 0. Reset mid-copy aborts the copy; no Done pulse follows.
- FunSel, applied at the edge to each enabled register:
  - 000 decrement, wrap mod 2^WIDTH (0→all ones).
  - 001 increment, wrap (all ones→0).
  - 010 load I.
  - 011 clear.
  - 100 logical shift left, 0 into LSB.
  - 101 logical shift right, 0 into MSB.
  - 110 rotate left.
  - 111 rotate right.
- Disabled registers hold their value. Multiple enables are allowed; all enabled registers receive the same operation.
- Reads: OutA/OutB are purely combinational on the current register contents, with zero latency; a write becomes visible the cycle after its edge. Out-of-range indices (when NUM_R+NUM_S < 2^SEL_W) return 0. Both ports may select the same register.
- FSM states: IDLE, COPY.
  - IDLE: if CopyStart=1 at the edge, latch CopyDir, set idx=0, go to COPY, Busy=1 next cycle.
  - COPY: each edge writes dst[idx]←src[idx] and increments idx. On the edge with idx=NUM_R-1, go to IDLE, Busy=0, Done=1 for exactly the following cycle.
- Copy latency: CopyStart sampled at edge k → Busy high for cycles k+1..k+NUM_R → Done high in cycle k+NUM_R+1. Scratch registers S(NUM_R)..S(NUM_S-1) are untouched by a copy.
- While Busy=1:
  - RegSel/ScrSel/FunSel are ignored for both banks.
  - CopyStart is ignored and is not queued.
  - Reads remain live and show partially copied state.
- CopyStart in the same cycle as Done=1 is accepted, since the FSM is already IDLE; back-to-back copies are therefore possible.
- Reset has priority over everything; the copy engine has priority over FunSel writes.

Decomposition:
- Shared package param_reg_file_pkg holds:
  - FunSel localparams FS_DEC, FS_INC, FS_LOAD, FS_CLR, FS_SHL, FS_SHR, FS_ROL, FS_ROR.
  - The copy FSM state encoding.
  - Copy-direction constants DIR_SAVE=0, DIR_RESTORE=1.
- One sub-module, param_register: a WIDTH-bit register with Clock, Reset, FunSel, active-low enable and I. It also has a copy-load override input and value, which take priority over FunSel.
- The top level instantiates NUM_R+NUM_S copies via generate and contains the read muxes and the copy FSM.

Test Plan (WIDTH=16, NUM_R=4, NUM_S=4):
1. Reset then load: Reset=1 for one edge; then FunSel=010, I=0x1234, RegSel=0111. Next cycle OutASel=0 → 0x1234; OutBSel=1 → 0x0000.
2. Arithmetic and shift wrap:
   - R1=0xFFFF, FunSel=001 → 0x0000; FunSel=000 → 0xFFFF.
   - R2=0x8001 with 100 → 0x0002, with 110 → 0x0003, with 111 → 0xC000.
3. Save: R0..R3=0x1111/0x2222/0x3333/0x4444, CopyStart=1, CopyDir=0.
   - Busy high exactly 4 cycles, then Done for 1 cycle.
   - S0..S3 then read 0x1111..0x4444; R bank unchanged.
4. Writes during Busy: issue RegSel=0000, FunSel=011 during the copy → R bank unchanged. A second CopyStart during Busy is ignored, giving exactly one Done pulse.
5. Reset mid-copy: restore started with S=0xAAAA.., Reset asserted in the 2nd Busy cycle → all registers 0, Busy=0, no Done.
6. Back-to-back: CopyStart held high across Done → the second copy begins immediately, giving Busy high for 4 cycles again with the Done cycle between the two Busy windows.
